// File: rtl/mfcc_melbank_reader.sv
// Mel-filter weight ROM reader: sweeps the ROM, multiplies each weight with its power bin and
// emits one accumulated mel energy per frame. Optional build macro MELBANK_OUT_SAT_EN saturates mel_data.
module mfcc_melbank_reader #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1,
  parameter int PWR_WIDTH   = 32,
  parameter int OUT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  input  logic                  pwr_valid,
  output logic                  pwr_ready,
  input  logic [PWR_WIDTH-1:0]  pwr_data,
  input  logic                  pwr_last,
  output logic                  mel_valid,
  output logic [OUT_WIDTH-1:0]  mel_data,
  output logic                  frame_err
);

  localparam int PROD_W = PWR_WIDTH + DATA_WIDTH;
  localparam int ACC_W  = PROD_W + ADDR_WIDTH;
  localparam int SCL_W  = ACC_W - DATA_WIDTH;
  localparam int EXT_W  = SCL_W + OUT_WIDTH;
  localparam int WAIT_W = (ROM_LATENCY < 2) ? 1 : $clog2(ROM_LATENCY + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(ROM_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MAC   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_k;
  logic [WAIT_W-1:0]   r_wait;
  logic [DATA_WIDTH-1:0] r_weight;
  logic [PROD_W-1:0]   r_prod;
  logic                r_prod_vld;
  logic [ACC_W-1:0]    r_acc;

  logic                w_hs;
  logic                w_at_last;
  logic [PROD_W-1:0]   w_prod;
  logic [EXT_W-1:0]    w_scaled_ext;

  // Scaled result is zero-extended by OUT_WIDTH so the overflow slice is always non-empty.
  function automatic logic [OUT_WIDTH-1:0] shape_out(input logic [EXT_W-1:0] v);
`ifdef MELBANK_OUT_SAT_EN
    if (|v[EXT_W-1:OUT_WIDTH]) begin
      shape_out = {OUT_WIDTH{1'b1}};
    end else begin
      shape_out = v[OUT_WIDTH-1:0];
    end
`else
    shape_out = v[OUT_WIDTH-1:0];
`endif
  endfunction

  assign w_hs         = pwr_valid & pwr_ready;
  assign w_at_last    = (r_k == LAST_BIN);
  assign w_prod       = PROD_W'(pwr_data) * PROD_W'(r_weight);
  assign w_scaled_ext = {{OUT_WIDTH{1'b0}}, r_acc[ACC_W-1:DATA_WIDTH]};

  // Frame sequencer, product pipeline and accumulator; all outputs registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_wait     <= '0;
      r_weight   <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      busy       <= 1'b0;
      rom_addr   <= '0;
      pwr_ready  <= 1'b0;
      mel_valid  <= 1'b0;
      mel_data   <= '0;
      frame_err  <= 1'b0;
    end else begin
      mel_valid  <= 1'b0;
      frame_err  <= 1'b0;
      r_prod_vld <= 1'b0;
      if (r_prod_vld) begin
        r_acc <= r_acc + ACC_W'(r_prod);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= FETCH;
            busy     <= 1'b1;
            r_k      <= '0;
            rom_addr <= '0;
            r_wait   <= '0;
            r_acc    <= '0;
          end
        end
        FETCH: begin
          r_wait <= r_wait + WAIT_W'(1);
          if (r_wait == WAIT_LAST) begin
            r_weight  <= rom_rd_data;
            pwr_ready <= 1'b1;
            r_state   <= MAC;
          end
        end
        MAC: begin
          if (w_hs) begin
            pwr_ready <= 1'b0;
            r_prod    <= w_prod;
            if (w_at_last && pwr_last) begin
              r_prod_vld <= 1'b1;
              r_wait     <= '0;
              r_state    <= FLUSH;
            end else if (w_at_last || pwr_last) begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_prod_vld <= 1'b1;
              r_k        <= r_k + ADDR_WIDTH'(1);
              rom_addr   <= r_k + ADDR_WIDTH'(1);
              r_wait     <= '0;
              r_state    <= FETCH;
            end
          end
        end
        FLUSH: begin
          // First cycle lets the final product land in the accumulator.
          if (r_wait == '0) begin
            r_wait <= WAIT_W'(1);
          end else begin
            mel_valid <= 1'b1;
            mel_data  <= shape_out(w_scaled_ext);
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc_melbank_reader.sv
// Scoreboard bench for mfcc_melbank_reader: three instances (ROM latency 1, ROM latency 2, 16-bit output).
module tb_mfcc_melbank_reader;

  localparam int NB = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  start_v;
  logic [2:0]  pwr_valid_v;
  logic [31:0] pwr_data;
  logic        pwr_last;

  logic busy0, busy1, busy2, rdy0, rdy1, rdy2, mv0, mv1, mv2, fe0, fe1, fe2;
  logic [8:0]  addr0, addr1, addr2;
  logic [7:0]  rom_data0, rom_data1, rom_data2;
  logic [31:0] mel0, mel1;
  logic [15:0] mel2;
  logic [2:0]  busy_v, rdy_v, mv_v, fe_v;

  assign busy_v    = {busy2, busy1, busy0};
  assign rdy_v     = {rdy2, rdy1, rdy0};
  assign mv_v      = {mv2, mv1, mv0};
  assign fe_v      = {fe2, fe1, fe0};
  assign rom_data0 = addr0[7:0];
  assign rom_data2 = addr2[7:0];

  // Registered-output weight ROM for the latency-2 instance.
  always @(posedge clk) rom_data1 <= addr1[7:0];

  mfcc_melbank_reader u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy0), .rom_addr(addr0),
    .rom_rd_data(rom_data0), .pwr_valid(pwr_valid_v[0]), .pwr_ready(rdy0), .pwr_data(pwr_data),
    .pwr_last(pwr_last), .mel_valid(mv0), .mel_data(mel0), .frame_err(fe0));

  mfcc_melbank_reader #(.ROM_LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy1), .rom_addr(addr1),
    .rom_rd_data(rom_data1), .pwr_valid(pwr_valid_v[1]), .pwr_ready(rdy1), .pwr_data(pwr_data),
    .pwr_last(pwr_last), .mel_valid(mv1), .mel_data(mel1), .frame_err(fe1));

  mfcc_melbank_reader #(.OUT_WIDTH(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy2), .rom_addr(addr2),
    .rom_rd_data(rom_data2), .pwr_valid(pwr_valid_v[2]), .pwr_ready(rdy2), .pwr_data(pwr_data),
    .pwr_last(pwr_last), .mel_valid(mv2), .mel_data(mel2), .frame_err(fe2));

  typedef struct {
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          mel_cnt[3];
  int          err_cnt[3];
  logic [31:0] last_mel[3];

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] req);
    vectors++;
    if (obs !== req) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, obs, req, $time);
    end
  endtask

  function automatic logic [8:0] addr_of(input int s);
    case (s)
      0:       return addr0;
      1:       return addr1;
      default: return addr2;
    endcase
  endfunction

  function automatic logic [31:0] mel_of(input int s);
    case (s)
      0:       return mel0;
      1:       return mel1;
      default: return {16'h0000, mel2};
    endcase
  endfunction

  // Expected output after scaling: truncation, or clamping when the saturating build is selected.
  function automatic logic [31:0] shape(input int s, input logic [63:0] scaled);
    logic [63:0] mask;
    mask = (s == 2) ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_FFFF_FFFF;
`ifdef MELBANK_OUT_SAT_EN
    if (scaled > mask) return mask[31:0];
    else return scaled[31:0];
`else
    return scaled[31:0] & mask[31:0];
`endif
  endfunction

  // Result monitor: pops the scoreboard on every mel_valid and counts error pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mv_v[i]) begin
        mel_cnt[i]++;
        check_value("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check_value("sb_sel", 64'(mon_e.sel), 64'(i));
          check_value("mel_data", 64'(mel_of(i)), 64'(mon_e.val));
        end
        check_value("busy_at_valid", 64'(busy_v[i]), 64'd0);
      end
      if (fe_v[i]) err_cnt[i]++;
    end
  end

  task automatic check_reset_vals(input int sel);
    check_value("rst_busy", 64'(busy_v[sel]), 64'd0);
    check_value("rst_addr", 64'(addr_of(sel)), 64'd0);
    check_value("rst_ready", 64'(rdy_v[sel]), 64'd0);
    check_value("rst_valid", 64'(mv_v[sel]), 64'd0);
    check_value("rst_mel", 64'(mel_of(sel)), 64'd0);
    check_value("rst_err", 64'(fe_v[sel]), 64'd0);
  endtask

  task automatic reset_abort(input int sel);
    @(negedge clk);
    pwr_valid_v[sel] = 1'b0;
    pwr_last = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals(sel);
    repeat (2) @(negedge clk);
    check_reset_vals(sel);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_mel[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_value("abort_no_mel", 64'(sb_q.size()), 64'd0);
  endtask

  // Drives one frame; last_bin<0 means pwr_last is never raised across NB bins.
  task automatic run_frame(input int sel, input logic [31:0] pv, input int last_bin,
                           input bit rnd, input bit extra_start, input int abort_bin,
                           input bit chk_gap);
    int          nbins;
    int          guard;
    int          cyc;
    int          prev_cyc;
    int          rdy_cnt;
    bit          have_prev;
    bit          extra_done;
    bit          accepted;
    bit          good;
    int          m0;
    int          e0;
    logic [63:0] acc;
    logic [31:0] expv;
    nbins = (last_bin >= 0) ? last_bin + 1 : NB;
    good = (last_bin == NB - 1);
    acc = 64'd0;
    cyc = 0; prev_cyc = 0; rdy_cnt = 0; have_prev = 1'b0; extra_done = 1'b0;
    accepted = 1'b0;
    m0 = mel_cnt[sel];
    e0 = err_cnt[sel];
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    check_value("busy_after_start", 64'(busy_v[sel]), 64'd1);
    for (int b = 0; b < nbins; b++) begin
      if (b == abort_bin) begin
        reset_abort(sel);
        return;
      end
      acc += 64'(pv) * 64'(b % 256);
      guard = 0;
      do begin
        @(negedge clk);
        if (chk_gap && rdy_v[sel]) begin
          rdy_cnt++;
          if (have_prev) check_value("ready_gap", 64'(cyc - prev_cyc), 64'd3);
          prev_cyc = cyc;
          have_prev = 1'b1;
        end
        cyc++;
        start_v[sel] = extra_start && (b == 200) && !extra_done;
        if (start_v[sel]) extra_done = 1'b1;
        pwr_valid_v[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pwr_data = pv;
        pwr_last = (b == last_bin);
        accepted = pwr_valid_v[sel] && rdy_v[sel];
        guard++;
      end while (!accepted && guard < 50);
      if (!accepted) begin
        check_value("handshake_timeout", 64'(accepted), 64'd1);
        pwr_valid_v[sel] = 1'b0;
        return;
      end
      check_value("rom_addr", 64'(addr_of(sel)), 64'(b));
    end
    if (chk_gap) check_value("ready_count", 64'(rdy_cnt), 64'(NB));
    if (good) begin
      expv = shape(sel, acc >> 8);
      sb_q.push_back('{sel: sel, val: expv});
      last_mel[sel] = expv;
    end
    @(negedge clk);
    pwr_valid_v[sel] = 1'b0;
    pwr_last = 1'b0;
    start_v[sel] = 1'b0;
    check_value("frame_err_timing", 64'(fe_v[sel]), 64'(!good));
    if (good) begin
      @(negedge clk);
      check_value("mel_early", 64'(mv_v[sel]), 64'd0);
      @(negedge clk);
      check_value("mel_timing", 64'(mv_v[sel]), 64'd1);
    end
    guard = 0;
    while (mel_cnt[sel] == m0 && err_cnt[sel] == e0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    check_value("mel_pulses", 64'(mel_cnt[sel] - m0), 64'(good));
    check_value("err_pulses", 64'(err_cnt[sel] - e0), 64'(!good));
    check_value("busy_idle", 64'(busy_v[sel]), 64'd0);
    check_value("mel_hold", 64'(mel_of(sel)), 64'(last_mel[sel]));
    check_value("sb_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    start_v = 3'b000;
    pwr_valid_v = 3'b000;
    pwr_data = 32'h0;
    pwr_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mel_cnt[i] = 0;
      err_cnt[i] = 0;
      last_mel[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 32'd1, NB - 1, 1'b0, 1'b0, -1, 1'b0);
    run_frame(1, 32'd256, NB - 1, 1'b0, 1'b0, -1, 1'b1);
    run_frame(2, 32'h0010_0000, NB - 1, 1'b0, 1'b0, -1, 1'b0);
    run_frame(0, 32'd1, 99, 1'b0, 1'b0, -1, 1'b0);
    run_frame(0, 32'd1, -1, 1'b0, 1'b0, -1, 1'b0);
    run_frame(0, 32'd3, NB - 1, 1'b0, 1'b0, -1, 1'b0);
    run_frame(0, 32'hFFFF_FFFF, NB - 1, 1'b0, 1'b0, -1, 1'b0);
    run_frame(0, 32'd1, NB - 1, 1'b0, 1'b0, 300, 1'b0);
    run_frame(0, 32'd1, NB - 1, 1'b0, 1'b0, -1, 1'b0);
    run_frame(0, 32'd1, NB - 1, 1'b1, 1'b1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mfcc_melbank_reader.md
Name: mfcc_melbank_reader

Overview:
- Consumer side of the MFCC mel-filter weight ROMs. Per frame it sweeps the ROM address, aligns each returned weight with the matching FFT power bin, multiply-accumulates, and emits one mel-filter energy.
- Sits between the FFT power-spectrum stage and the log/DCT stage. One instance serves one filter ROM.

Parameters:
- ADDR_WIDTH, 9, ROM address width; frame length NUM_BINS = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, ROM weight width; unsigned Q0.DATA_WIDTH.
- ROM_LATENCY, 1, ROM read latency in clocks: 1 = unregistered output, 2 = output register.
- PWR_WIDTH, 32, unsigned power-bin width.
- OUT_WIDTH, 32, mel energy output width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start pulse; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until mel_valid or frame_err.
- rom_addr  out  ADDR_WIDTH  weight ROM address.
- rom_rd_data  in  DATA_WIDTH  weight ROM read data.
- pwr_valid  in  1  power bin valid.
- pwr_ready  out  1  power bin accepted when pwr_valid & pwr_ready.
- pwr_data  in  PWR_WIDTH  power bin value.
- pwr_last  in  1  marks the final bin of the frame.
- mel_valid  out  1  one-cycle result pulse.
- mel_data  out  OUT_WIDTH  mel energy; held until the next result.
- frame_err  out  1  one-cycle pulse when the frame length is wrong.

Behaviour:
- Reset values: busy=0, rom_addr=0, pwr_ready=0, mel_valid=0, mel_data=0, frame_err=0. FSM=IDLE, accumulator=0, bin counter k=0.
- Reset asserted mid-frame aborts immediately to IDLE with no pulse.
- FSM states: IDLE, FETCH, MAC, FLUSH.
- IDLE: on start go to FETCH. Set k=0, rom_addr=0, clear accumulator and wait counter.
- FETCH: rom_addr is held at k. The wait counter increments each cycle. When it reaches ROM_LATENCY, the weight for bin k is captured and the FSM goes to MAC.
- MAC: pwr_ready=1. On handshake, product = pwr_data*weight, full width PWR_WIDTH+DATA_WIDTH, is registered.
  - If k==NUM_BINS-1 and pwr_last=1: go to FLUSH.
  - If pwr_last=1 with k<NUM_BINS-1, or pwr_last=0 with k==NUM_BINS-1: pulse frame_err on the next cycle, drop the frame, return to IDLE. mel_valid stays 0 and mel_data is unchanged.
  - Otherwise: k=k+1, rom_addr=k+1, wait counter=0, go to FETCH.
- pwr_ready is 0 in every state except MAC. Steady throughput is one bin per ROM_LATENCY+1 cycles.
- Accumulator: ACC_WIDTH = PWR_WIDTH+DATA_WIDTH+ADDR_WIDTH; cannot overflow. The product register adds into it one cycle after the handshake.
- FLUSH: waits for the last add to complete. mel_valid pulses on the 2nd rising edge after the last-bin handshake edge. On that same edge mel_data is loaded and busy drops; the FSM returns to IDLE.
- Scaling: scaled = acc >> DATA_WIDTH. mel_data = low OUT_WIDTH bits of scaled, unless the optional feature below is compiled in.
- rom_addr wraps only through reset or a new start; it never exceeds NUM_BINS-1.
- start coinciding with the mel_valid edge is ignored, because busy is still 1 on that edge.

Optional Feature:
- Macro MELBANK_OUT_SAT_EN.
- Defined: if any bit of scaled above OUT_WIDTH-1 is set, mel_data = all ones; otherwise mel_data = scaled.
- Undefined: plain truncation to the low OUT_WIDTH bits.
- No timing or handshake difference between the two builds.

Test Plan:
- ROM model w[k]=k[7:0], ROM_LATENCY=1, pwr_data=1 for all 512 bins, pwr_last on bin 511 -> one mel_valid pulse, mel_data=255 (65280>>8), frame_err never asserted.
- Same ROM, pwr_data=256 all bins, pwr_valid held high, ROM_LATENCY=2 -> pwr_ready high exactly 1 of every 3 cycles; mel_data=65280; busy low on the mel_valid cycle.
- OUT_WIDTH=16, pwr_data=2^20 all bins -> with MELBANK_OUT_SAT_EN mel_data=16'hFFFF; without it mel_data=16'h0000 (0xFF00000 truncated).
- pwr_last asserted on bin 99 -> frame_err pulses once, no mel_valid, busy=0, previous mel_data retained; the next full frame produces the correct result.
- rst_n pulled low at bin 300, then released, then a fresh start -> all outputs at reset values while low; the subsequent frame result matches case 1.
- pwr_valid random 50% duty plus a start pulse issued while busy -> extra start ignored; mel_data equals case 1 value; exactly one mel_valid.
